counter_load_rx: RTL and testbench
==================================

Name: counter_load_rx

Overview:
Serial load front-end for the 8-bit loadable counter. It receives asynchronous 8N1 UART frames on a single line and converts each good byte into a one-cycle wr strobe plus wdata value. Its outputs wire directly to the counter's wdata and wr inputs. It runs on the counter's clock and reset.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..1023, elaborate-time $error outside it.
DATA_W, 8, payload bits per frame; fixed at 8 for the counter, kept as a parameter for reuse.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
rxd  input  1  asynchronous serial line, idle high.
wdata  output  DATA_W  last correctly received byte, held until the next good frame.
wr  output  1  single-cycle load strobe for the counter.
frame_err  output  1  single-cycle pulse on a bad stop bit.
busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (reset=0, async): wdata=0x00, wr=0, frame_err=0, busy=0, FSM=IDLE, bit and clk counters=0, both synchronizer flops=1. On release the block starts in IDLE with no strobe.
- rxd passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. There is a fixed 2-cycle input latency.
- Baud counter width is $clog2(CLKS_PER_BIT). Half-bit point is HALF=CLKS_PER_BIT/2, integer division.
- State IDLE: on rx_s falling (prev 1, now 0), go to START and clear the baud counter.
- State START: wait HALF-1 cycles, then sample rx_s.
  - If the sample is 0, it is a valid start: go to DATA with bit index 0 and clear the baud counter.
  - If the sample is 1, it is a glitch: return to IDLE. No output changes.
- State DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit DATA_W-1, go to STOP.
- State STOP: after CLKS_PER_BIT cycles, sample rx_s (mid stop bit).
  - If the sample is 1: load wdata from the shift register and pulse wr=1 for exactly one cycle. The pulse starts on the clk edge after the sample. Return to IDLE.
  - If the sample is 0: leave wdata unchanged, wr stays 0, and pulse frame_err=1 for one cycle. Go to WAIT_IDLE.
- State WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers a break condition, so a held-low line never produces repeated frames or errors.
- wr and frame_err are never high together. Each is a registered output with no combinational path from rxd.
- Back-to-back frames: returning to IDLE at mid stop bit allows a start edge that immediately follows the stop bit to be detected. There is no minimum idle gap.
- Reset asserted mid-frame aborts immediately. The partial byte is discarded, and no wr or frame_err is emitted at release.
- Latency: wr rises about 2 + HALF + (DATA_W+1)*CLKS_PER_BIT + 1 cycles after the rxd falling edge, ±1 cycle for edge alignment.

Test Plan:
- CLKS_PER_BIT=16, clk period 20 (bit time 320): reset low for 50, then send 0x55 with one stop bit -> exactly one wr pulse of 20 time units, wdata=0x55, frame_err never high, busy low afterwards.
- Send 0xA3 immediately followed by 0x0F with no idle gap -> two separate wr pulses with wdata 0xA3 then 0x0F, pulses about 10 bit times apart.
- Drive rxd low for 4 clk cycles, then high -> no wr, no frame_err, busy returns to 0 within HALF+3 cycles, wdata keeps its previous value.
- Send 0x3C with the stop bit driven 0 and hold rxd low for 30 bit times -> one frame_err pulse, wr=0, wdata unchanged, no further events until the line goes high; a following 0x81 frame is then received correctly.
- Assert reset during data bit 4 of a 0xFF frame -> wdata=0x00, wr=0, busy=0 immediately; after release and a full 0x12 frame, wdata=0x12 with a single wr pulse.
- Send 0x00 and 0xFF as edge payloads -> wdata equals each byte exactly, and each produces one wr.

Source files
------------

// File: rtl/counter_load_rx_if.sv
// ---------------------------------------------------------------------------
// counter_load_rx_if
//   Groups the serial load front-end's line input and its counter-side
//   outputs into one bundle.
//
//   Signals:
//     rxd        serial line, idle high (driven by the line side)
//     wdata      last good byte, held until the next good frame
//     wr         one-cycle load strobe for the counter
//     frame_err  one-cycle pulse on a bad stop bit
//     busy       high while a frame is in progress
//
//   Modports:
//     master  the receiver: samples rxd, drives the counter-side outputs
//     slave   the surroundings: drive rxd, observe the receiver outputs
// ---------------------------------------------------------------------------
interface counter_load_rx_if #(
    parameter int DATA_W = 8
);
    logic              rxd;
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              frame_err;
    logic              busy;

    modport master (
        input  rxd,
        output wdata,
        output wr,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        input  wdata,
        input  wr,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/counter_load_rx.sv
// ---------------------------------------------------------------------------
// counter_load_rx
//   Serial load front-end for the 8-bit loadable counter. Receives 8N1 UART
//   frames on bus.rxd and turns each good byte into a one-cycle bus.wr
//   strobe with the byte on bus.wdata. A bad stop bit produces a one-cycle
//   bus.frame_err pulse instead, and the receiver then waits for the line
//   to return high before looking for another start edge.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    counter_load_rx_if.master (rxd in; wdata/wr/frame_err/busy out)
//
//   Parameters:
//     CLKS_PER_BIT  clk cycles per serial bit, 4..1023
//     DATA_W        payload bits per frame
// ---------------------------------------------------------------------------
module counter_load_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_load_rx_if.master      bus
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1023) begin : g_bad_clks_per_bit
        $error("counter_load_rx: CLKS_PER_BIT=%0d outside 4..1023", CLKS_PER_BIT);
    end

    if (DATA_W < 2) begin : g_bad_data_w
        $error("counter_load_rx: DATA_W=%0d must be at least 2", DATA_W);
    end

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   bit_idx_n;
    logic               shift_en;
    logic               wr_n;
    logic               ferr_n;

    logic               rx_p0;
    logic               rx_s;
    logic               rx_prev;
    logic [DATA_W-1:0]  shift_p0;
    logic [DATA_W-1:0]  wdata_r;
    logic               wr_r;
    logic               ferr_r;

    // Stage 0: two-flop synchronizer on the asynchronous line, plus one
    // more flop of history for start-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_p0   <= bus.rxd;
            rx_s    <= rx_p0;
            rx_prev <= rx_s;
        end
    end

    // Next-state and strobe decode. wr_n/ferr_n are only registered, so
    // neither output has a combinational path from the line.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_en  = 1'b0;
        wr_n      = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end

            START: begin
                // Re-check the line at mid start bit so a short glitch
                // does not start a frame.
                if (cnt == HALF_END) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            STOP: begin
                // Leaving at mid stop bit lets a start edge that follows
                // the stop bit directly be seen from IDLE.
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        wr_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            WAIT_IDLE: begin
                // A held-low line (break) parks here until it goes high.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Stage 1: control state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            wr_r    <= 1'b0;
            ferr_r  <= 1'b0;
            wdata_r <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            wr_r    <= wr_n;
            ferr_r  <= ferr_n;
            if (wr_n) begin
                wdata_r <= shift_p0;
            end
        end
    end

    // Stage 1: payload shift register, LSB first; new bits enter at the
    // top so the first bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_p0 <= {rx_s, shift_p0[DATA_W-1:1]};
        end
    end

    assign bus.wdata     = wdata_r;
    assign bus.wr        = wr_r;
    assign bus.frame_err = ferr_r;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_counter_load_rx.sv
// ---------------------------------------------------------------------------
// tb_counter_load_rx
//   Directed bench for counter_load_rx with CLKS_PER_BIT=16 and a 20-unit
//   clock. Frames are driven bit by bit on the line; a negedge monitor logs
//   every wr pulse (with wdata and cycle number) and every frame_err pulse.
// ---------------------------------------------------------------------------
module tb_counter_load_rx;

    localparam int CPB    = 16;
    localparam int DATA_W = 8;
    localparam int HALF   = CPB / 2;

    logic clk;
    logic reset;

    counter_load_rx_if #(.DATA_W(DATA_W)) bus ();

    counter_load_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor
    int         cyc       = 0;
    int         wr_count  = 0;
    int         ferr_count = 0;
    int         wr_long   = 0;
    int         ferr_long = 0;
    int         both_high = 0;
    logic       wr_prev   = 1'b0;
    logic       ferr_prev = 1'b0;
    logic [7:0] wr_log[$];
    int         wr_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.wr === 1'b1) begin
            wr_count++;
            wr_log.push_back(bus.wdata);
            wr_cyc.push_back(cyc);
            if (wr_prev) wr_long++;
        end
        if (bus.frame_err === 1'b1) begin
            ferr_count++;
            if (ferr_prev) ferr_long++;
        end
        if (bus.wr === 1'b1 && bus.frame_err === 1'b1) both_high++;
        wr_prev   = (bus.wr === 1'b1);
        ferr_prev = (bus.frame_err === 1'b1);
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int fall_cyc;

    // Each call starts and ends 2 time units after a rising edge.
    task automatic drive_bit(input logic b);
        bus.rxd = b;
        repeat (CPB) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        bus.rxd = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #2;
    endtask

    int base_wr;
    int base_ferr;
    int lat;
    int gap;

    initial begin
        reset   = 1'b0;
        bus.rxd = 1'b1;

        // Reset state
        #45;
        check_eq("reset_wdata", {24'd0, bus.wdata}, 32'h00);
        check_eq("reset_wr", {31'd0, bus.wr}, 32'd0);
        check_eq("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
        #5;
        @(posedge clk);
        #2;
        reset = 1'b1;
        idle_bits(1);

        // Single frame 0x55
        base_wr = wr_count;
        send_byte(8'h55, 1'b1);
        idle_bits(2);
        check_eq("f55_wr_count", wr_count - base_wr, 1);
        check_eq("f55_wdata", {24'd0, bus.wdata}, 32'h55);
        check_eq("f55_logged", {24'd0, wr_log[base_wr]}, 32'h55);
        check_eq("f55_ferr", ferr_count, 0);
        check_eq("f55_busy", {31'd0, bus.busy}, 32'd0);
        lat = wr_cyc[base_wr] - fall_cyc - 1;
        check_eq("f55_latency", (lat >= 154 && lat <= 156) ? 1 : 0, 1);

        // Back-to-back 0xA3 / 0x0F, no idle gap
        base_wr = wr_count;
        send_byte(8'hA3, 1'b1);
        send_byte(8'h0F, 1'b1);
        idle_bits(2);
        check_eq("b2b_wr_count", wr_count - base_wr, 2);
        check_eq("b2b_first", {24'd0, wr_log[base_wr]}, 32'hA3);
        check_eq("b2b_second", {24'd0, wr_log[base_wr + 1]}, 32'h0F);
        gap = wr_cyc[base_wr + 1] - wr_cyc[base_wr];
        check_eq("b2b_gap", (gap >= 10 * CPB - 1 && gap <= 10 * CPB + 1) ? 1 : 0, 1);

        // Start-bit glitch: 4 cycles low
        base_wr   = wr_count;
        base_ferr = ferr_count;
        bus.rxd = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        bus.rxd = 1'b1;
        check_eq("glitch_busy_during", {31'd0, bus.busy}, 32'd1);
        repeat (HALF + 3) @(posedge clk);
        #2;
        check_eq("glitch_busy_after", {31'd0, bus.busy}, 32'd0);
        idle_bits(1);
        check_eq("glitch_wr", wr_count - base_wr, 0);
        check_eq("glitch_ferr", ferr_count - base_ferr, 0);
        check_eq("glitch_wdata", {24'd0, bus.wdata}, 32'h0F);

        // Bad stop bit followed by a 30-bit-time break
        base_wr   = wr_count;
        base_ferr = ferr_count;
        send_byte(8'h3C, 1'b0);
        bus.rxd = 1'b0;
        repeat (30 * CPB) @(posedge clk);
        #2;
        check_eq("break_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("break_ferr_count", ferr_count - base_ferr, 1);
        idle_bits(2);
        check_eq("break_ferr_after", ferr_count - base_ferr, 1);
        check_eq("break_wr", wr_count - base_wr, 0);
        check_eq("break_wdata", {24'd0, bus.wdata}, 32'h0F);
        check_eq("break_busy_after", {31'd0, bus.busy}, 32'd0);
        base_wr = wr_count;
        send_byte(8'h81, 1'b1);
        idle_bits(2);
        check_eq("after_break_wr", wr_count - base_wr, 1);
        check_eq("after_break_wdata", {24'd0, bus.wdata}, 32'h81);

        // Reset during data bit 4 of 0xFF
        base_wr   = wr_count;
        base_ferr = ferr_count;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.rxd = 1'b1;
        repeat (HALF) @(posedge clk);
        #2;
        check_eq("midreset_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("midreset_wdata", {24'd0, bus.wdata}, 32'h00);
        check_eq("midreset_wr", {31'd0, bus.wr}, 32'd0);
        check_eq("midreset_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        idle_bits(2);
        check_eq("midreset_no_wr", wr_count - base_wr, 0);
        check_eq("midreset_no_ferr", ferr_count - base_ferr, 0);
        send_byte(8'h12, 1'b1);
        idle_bits(2);
        check_eq("post_reset_wr", wr_count - base_wr, 1);
        check_eq("post_reset_wdata", {24'd0, bus.wdata}, 32'h12);

        // Edge payloads
        base_wr = wr_count;
        send_byte(8'h00, 1'b1);
        idle_bits(2);
        check_eq("p00_wr", wr_count - base_wr, 1);
        check_eq("p00_wdata", {24'd0, bus.wdata}, 32'h00);
        send_byte(8'hFF, 1'b1);
        idle_bits(2);
        check_eq("pFF_wr", wr_count - base_wr, 2);
        check_eq("pFF_wdata", {24'd0, bus.wdata}, 32'hFF);

        // Whole-run pulse properties
        check_eq("wr_single_cycle", wr_long, 0);
        check_eq("ferr_single_cycle", ferr_long, 0);
        check_eq("wr_ferr_exclusive", both_high, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
